// File: rtl/sprite_blitter.sv
// sprite_blitter: stamps one palette-indexed sprite into the frame buffer.
// Pulls pixel indices from a one-cycle-latency sprite ROM and clips against
// the screen edges. It skips transparent pixels and issues single-cycle
// frame-buffer writes. Throughput is one sprite pixel per clock.
module sprite_blitter #(
    parameter int unsigned SPRITE_W    = 50,
    parameter int unsigned SPRITE_H    = 50,
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PAL_W       = 9,
    parameter int unsigned SPR_AW      = 13,
    parameter int unsigned FB_AW       = 20,
    parameter int unsigned TRANSPARENT = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [9:0]        xcoord_i,
    input  logic [8:0]        ycoord_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [SPR_AW-1:0] spr_addr_o,
    input  logic [PAL_W-1:0]  spr_data_i,
    output logic [FB_AW-1:0]  fb_addr_o,
    output logic [PAL_W-1:0]  fb_data_o,
    output logic              fb_we_o
);

    localparam int unsigned ColW = $clog2(SPRITE_W);
    localparam int unsigned RowW = $clog2(SPRITE_H);

    localparam logic [ColW-1:0]   ColLast  = ColW'(SPRITE_W - 1);
    localparam logic [SPR_AW-1:0] AddrLast = SPR_AW'(SPRITE_W * SPRITE_H - 1);
    localparam logic [10:0]       ScrW11   = 11'(SCREEN_W);
    localparam logic [9:0]        ScrH10   = 10'(SCREEN_H);
    localparam logic [FB_AW-1:0]  ScrWFb   = FB_AW'(SCREEN_W);
    localparam logic [PAL_W-1:0]  Transp   = PAL_W'(TRANSPARENT);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;
    logic [FB_AW-1:0]  ybase_q, ybase_d;      // y * SCREEN_W, fixed for the whole blit
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [FB_AW-1:0]  row_base_q, row_base_d; // row * SCREEN_W, accumulated
    logic [SPR_AW-1:0] spr_addr_q, spr_addr_d;
    logic              drain_q, drain_d;

    // Stage 1: screen position of the pixel whose ROM read is in flight
    logic              s1_valid_q, s1_vis_q;
    logic [FB_AW-1:0]  s1_addr_q;

    // Stage 2: frame-buffer write port
    logic              fb_we_q;
    logic [FB_AW-1:0]  fb_addr_q;
    logic [PAL_W-1:0]  fb_data_q;

    logic [10:0]       sx;
    logic [9:0]        sy;
    logic              vis;
    logic [FB_AW-1:0]  pix_addr;
    logic              fb_wr;

    // Stage-1 coordinate and address arithmetic; no multiplier on col
    always_comb begin
        sx       = {1'b0, x_q} + 11'(col_q);
        sy       = {1'b0, y_q} + 10'(row_q);
        vis      = (sx < ScrW11) && (sy < ScrH10);
        pix_addr = ybase_q + row_base_q + FB_AW'(sx);
        fb_wr    = s1_valid_q && s1_vis_q && (spr_data_i != Transp);
    end

    // Next-state logic for the blit sequencer and its raster counters
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        ybase_d    = ybase_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        spr_addr_d = spr_addr_q;
        drain_d    = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    x_d        = xcoord_i;
                    y_d        = ycoord_i;
                    ybase_d    = FB_AW'(ycoord_i) * ScrWFb;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    spr_addr_d = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (spr_addr_q == AddrLast) begin
                    drain_d = 1'b0;
                    state_d = StDrain;
                end else begin
                    spr_addr_d = spr_addr_q + 1'b1;
                    if (col_q == ColLast) begin
                        col_d      = '0;
                        row_d      = row_q + 1'b1;
                        row_base_d = row_base_q + ScrWFb;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            ybase_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            spr_addr_q <= '0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            ybase_q    <= ybase_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            spr_addr_q <= spr_addr_d;
            drain_q    <= drain_d;
        end
    end

    // Two-stage write pipeline aligned with the ROM read latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_vis_q   <= 1'b0;
            s1_addr_q  <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            s1_valid_q <= (state_q == StRun);
            s1_vis_q   <= vis;
            s1_addr_q  <= pix_addr;
            fb_we_q    <= fb_wr;
            if (fb_wr) begin
                fb_addr_q <= s1_addr_q;
                fb_data_q <= spr_data_i;
            end
        end
    end

    // Output mapping
    always_comb begin
        busy_o     = (state_q == StRun) || (state_q == StDrain);
        done_o     = (state_q == StDone);
        spr_addr_o = spr_addr_q;
        fb_addr_o  = fb_addr_q;
        fb_data_o  = fb_data_q;
        fb_we_o    = fb_we_q;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Writes one palette-indexed sprite (default 50x50) into the 640x480 frame-buffer RAM at a requested screen coordinate. It is the write-side counterpart of the sprite image readers. It pulls sprite pixel indices from a sprite ROM with a one-cycle read latency, clips against the screen edges, skips transparent pixels, and issues single-cycle frame-buffer writes. The game logic drives it with a start/busy/done handshake when a fruit or splash is stamped into the background.

## Interface
- SPRITE_W, 50, sprite width in pixels
- SPRITE_H, 50, sprite height in pixels
- SCREEN_W, 640, frame-buffer width
- SCREEN_H, 480, frame-buffer height
- PAL_W, 9, palette index width ($clog2(256)+1)
- SPR_AW, 13, sprite ROM address width ($clog2(SPRITE_W*SPRITE_H)+1)
- FB_AW, 20, frame-buffer address width ($clog2(SCREEN_W*SCREEN_H)+1)
- TRANSPARENT, 0, palette index that is never written
- clk  in  1  system clock; all state on the rising edge
- resetn  in  1  reset: one clock; reset is asynchronous and active-low
- start  in  1  request a blit; sampled only in IDLE
- xcoord  in  10  screen x of sprite top-left, latched on accepted start
- ycoord  in  9  screen y of sprite top-left, latched on accepted start
- busy  out  1  high while a blit is in progress
- done  out  1  one-cycle pulse when a blit completes
- sprAddr  out  SPR_AW  sprite ROM read address (registered)
- sprData  in  PAL_W  sprite ROM data; valid the cycle after sprAddr
- fbAddr  out  FB_AW  frame-buffer write address (registered)
- fbData  out  PAL_W  frame-buffer write data (registered)
- fbWEn  out  1  frame-buffer write enable, one cycle per written pixel

## Operation
- States:
  - IDLE: on start=1, latch xcoord/ycoord, clear row/col/rowBase, go to RUN.
  - RUN: present sprAddr = row*SPRITE_W+col each cycle. col increments; on col=SPRITE_W-1, col wraps to 0, row increments and rowBase += SCREEN_W. After sprAddr = SPRITE_W*SPRITE_H-1, go to DRAIN.
  - DRAIN: 2 cycles to flush the pipeline, then DONE.
  - DONE: done=1 for 1 cycle, then IDLE.
- Pipeline stage 1 (cycle of sprAddr): compute sx = x+col (11 bits) and sy = y+row (10 bits).
  - visible = sx<SCREEN_W && sy<SCREEN_H.
  - addr = (y*SCREEN_W) + rowBase + sx. Use FB_AW-bit arithmetic with an accumulator; no multiplier on col. y*SCREEN_W is latched at start.
- Stage 2 (sprData valid): register fbAddr and fbData=sprData. fbWEn = stage1 valid && visible && sprData!=TRANSPARENT.
- Clipped and transparent pixels still consume their cycle; throughput is fixed at 1 pixel/cycle.
- start while busy or in DONE is ignored; no queuing.
- fbAddr/fbData hold their last value when fbWEn=0.

## Timing
- Reset values: busy=0, done=0, sprAddr=0, fbAddr=0, fbData=0, fbWEn=0, state IDLE.
- resetn low mid-blit: outputs go to reset values immediately (async). No done pulse and no further writes.
- Start sampled high at the edge ending cycle 0:
  - busy=1 in cycles 1..2502.
  - sprAddr=k in cycle 1+k (k=0..2499).
  - Write for pixel k appears in cycle 3+k.
  - done=1 and busy=0 in cycle 2503; IDLE in cycle 2504.
- General latency: start to done = SPRITE_W*SPRITE_H+3 cycles. ROM-address to write = 2 cycles.
- start held high continuously: the next blit is accepted in the first IDLE cycle (2504). The coordinates are sampled then.

## Test plan
- Reset: assert resetn=0 with random inputs -> all outputs 0. Release -> stays IDLE, busy=0.
- Opaque blit: ROM all index 5, start at (0,0) -> exactly 2500 writes.
  - First write fbAddr=0 in cycle 3; col49/row0 fbAddr=49; row1/col0 fbAddr=640; last fbAddr=31409.
  - All fbData=5; done in cycle 2503.
- Transparency: ROM index 0 at even addresses, 7 at odd, start at (100,50) -> 1250 writes, all fbData=7.
  - First write fbAddr=32101 in cycle 4.
- Clipping: ROM all 3, start at (620,470) -> 200 writes (cols 0..19, rows 0..9).
  - Max fbAddr=307199; no address ≥307200; done still at cycle 2503.
- Handshake: pulse start again at cycles 10 and 2503 -> both ignored.
  - Hold start high from 2504 with new coords -> second blit starts, sprAddr=0 in cycle 2505.
- Async reset mid-blit: resetn=0 at cycle 1000 -> fbWEn/busy drop without waiting for a clock edge; no done.
  - After release, a new start at (0,0) -> full 2500-write blit with correct addresses.
